mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the caches and the byte-wide synchronous RAM. Arbitrates instruction-cache refills and data-side loads/stores onto the single 8-bit RAM port. Serialises each 1/2/4-byte access into consecutive byte cycles and returns assembled words with a one-cycle ready pulse. It directly feeds `ram_busy`/`ram_ready`/`ram_data` of the instruction cache.

## Interface
Parameters: none. Widths come from `define.v` (`MemAddrBus` 31:0, `MemDataBus` 31:0, `RamDataBus` 7:0).
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- i_read  in  1  icache refill request (level)
- i_addr  in  32  icache word address
- i_discard  in  1  abort any in-flight instruction fetch
- i_busy  out  1  controller not idle
- i_ready  out  1  one-cycle pulse; i_data valid
- i_data  out  32  fetched word, little-endian
- d_read / d_write  in  1 each  data load / store request (never both)
- d_addr  in  32  byte address
- d_len  in  2  bytes-1: 0 byte, 1 half, 3 word; 2 illegal
- d_wdata  in  32  store data, low bytes used
- d_busy  out  1  same as i_busy
- d_ready  out  1  one-cycle pulse on load/store completion
- d_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read data; byte for address of previous cycle
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe

## Operation
- States: IDLE, IREAD, DREAD, DWRITE, DONE.
- Requests are sampled only in IDLE. Priority: d_write/d_read over i_read. A losing i_read stays asserted and is served next.
- On acceptance, latch base address, n = len+1 (4 for instruction), write data and target port. Clear byte counter k and assembly buffer.
- IREAD/DREAD:
  - Cycles 1..n: mem_a = base+k, mem_wr = 0.
  - Cycle k+2 captures mem_din into buf[8k+7:8k].
  - After the last capture, go to DONE.
- DWRITE: cycles 1..n: mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1. Then DONE.
- DONE: pulse the owning port's ready, drive buf on its data bus, then IDLE.
- i_data and d_rdata hold their value until the next completion on that port.
- Busy = (state != IDLE). This includes DONE, so the requester's delayed request cannot re-fire in its ready cycle.
- i_discard high in IREAD or DONE-for-I: return to IDLE next edge, no i_ready, i_data unchanged. In IDLE, an i_read with i_discard in the same cycle is not accepted. Ignored during data states.
- d_len = 2 is treated as 3.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset (and after any reset, mid-op included): state IDLE; all outputs 0 (busy, ready, mem_wr, mem_a, mem_dout, i_data, d_rdata). The in-flight op is dropped silently.
- All outputs are registered, except busy (decoded from registered state).
- Let cycle 0 be the IDLE cycle with the request sampled.
  - Read of n bytes: ready high in cycle n+2; word read: cycle 6.
  - Write of n bytes: ready in cycle n+1; word store: cycle 5.
- Next request can be accepted in the cycle after DONE (earliest back-to-back: one IDLE cycle).
- mem_wr is never high outside DWRITE.

## Structure
- `define.v` gains `RamDataBus` and the state encodings `MemIdle`, `MemIRead`, `MemDRead`, `MemDWrite`, `MemDone`.
- Single module, no sub-module: arbitration, counter and shift/assembly logic are small and tightly coupled.

## Test plan
- Reset mid-DWRITE (after 2 bytes) → mem_wr low next cycle, no d_ready, busy 0.
- i_read addr 0x1000, RAM bytes 0x13,0x05,0x00,0x00 → mem_a 0x1000..0x1003 in cycles 1–4; i_ready cycle 6 with i_data = 0x00000513; busy high cycles 1–6.
- d_read and i_read together in cycle 0 → data served first; i_read (held) accepted in the IDLE cycle after d_ready; exactly one i_ready.
- d_write d_len=1, addr 0x2FFFF, wdata 0xDEADBEEF → mem_wr cycles 1–2, (0x2FFFF,0xEF),(0x30000,0xBE); d_ready cycle 3.
- d_read d_len=0 at 0x8, mem byte 0xF0 → d_rdata = 0x000000F0 (zero-extended), d_ready cycle 3.
- i_discard in cycle 3 of IREAD → idle at cycle 4, no i_ready, i_data unchanged; a new i_read is accepted in cycle 4.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the byte-serial memory controller.
//   mem_state_e  - controller FSM encoding (also exported on the debug port)
//   len_to_bytes - maps a d_len code (bytes-1) to a byte count
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE   = 3'd0,
    MEM_IREAD  = 3'd1,
    MEM_DREAD  = 3'd2,
    MEM_DWRITE = 3'd3,
    MEM_DONE   = 3'd4
  } mem_state_e;

  localparam logic [2:0] IFETCH_BYTES = 3'd4;

  // The reserved length code 2 is widened to a full word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    if (len == 2'd2) n = 3'd4;
    else             n = {1'b0, len} + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache refills and data loads/stores onto one
// byte-wide synchronous RAM port, serialising 1/2/4-byte accesses.
//
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   i_read/i_addr        - icache word fetch request (level) and address
//   i_discard            - abort an in-flight instruction fetch
//   i_busy/i_ready/i_data- controller busy, completion pulse, fetched word
//   d_read/d_write       - data load/store request (level, never both)
//   d_addr/d_len/d_wdata - byte address, bytes-1 code, store data
//   d_busy/d_ready/d_rdata - busy, completion pulse, zero-extended load data
//   mem_din              - RAM read byte for the address of the previous cycle
//   mem_dout/mem_a/mem_wr- RAM write byte, byte address, write strobe
//   fsm_state            - debug view of the controller state
//
// Handshake: a request is a level held by the requester; it is sampled only
// while the controller is idle (busy low). Completion is a single-cycle ready
// pulse with the data bus valid in that same cycle; the data bus then holds
// until the next completion on that port. Busy stays high during the ready
// cycle so a requester that drops its request on ready cannot re-fire.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  input  logic        i_discard,
  output logic        i_busy,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_busy,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [2:0]  fsm_state
);

  mem_state_e  state;
  logic [31:0] base;
  logic [31:0] wdata_q;   // remaining store bytes, next one in [7:0]
  logic [31:0] asm_q;     // read assembly buffer
  logic [2:0]  n_q;       // bytes in this access
  logic [2:0]  cnt;       // cycles spent in the active state
  logic        owner_i;   // completion belongs to the instruction port

  logic [1:0]  cap_idx;
  logic [31:0] asm_next;
  logic [2:0]  cnt_inc;

  // In a read state, cycle cnt (cnt >= 1) sees the byte issued cnt-1 cycles
  // after entry, i.e. byte index cnt-1.
  always_comb begin
    cnt_inc  = cnt + 3'd1;
    cap_idx  = 2'(cnt - 3'd1);
    asm_next = asm_q | (32'(mem_din) << {cap_idx, 3'b000});
  end

  assign i_busy    = (state != MEM_IDLE);
  assign d_busy    = (state != MEM_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MEM_IDLE;
      base     <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      n_q      <= '0;
      cnt      <= '0;
      owner_i  <= 1'b0;
      i_ready  <= 1'b0;
      i_data   <= '0;
      d_ready  <= 1'b0;
      d_rdata  <= '0;
      mem_dout <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        MEM_IDLE: begin
          cnt   <= '0;
          asm_q <= '0;
          if (d_write) begin
            state    <= MEM_DWRITE;
            base     <= d_addr;
            mem_a    <= d_addr;
            n_q      <= len_to_bytes(d_len);
            mem_dout <= d_wdata[7:0];
            wdata_q  <= d_wdata >> 8;
            mem_wr   <= 1'b1;
            owner_i  <= 1'b0;
          end else if (d_read) begin
            state   <= MEM_DREAD;
            base    <= d_addr;
            mem_a   <= d_addr;
            n_q     <= len_to_bytes(d_len);
            owner_i <= 1'b0;
          end else if (i_read && !i_discard) begin
            state   <= MEM_IREAD;
            base    <= i_addr;
            mem_a   <= i_addr;
            n_q     <= IFETCH_BYTES;
            owner_i <= 1'b1;
          end
        end

        MEM_IREAD, MEM_DREAD: begin
          if (state == MEM_IREAD && i_discard) begin
            state <= MEM_IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc < n_q) mem_a <= base + 32'(cnt_inc);
            if (cnt != 3'd0)   asm_q <= asm_next;
            if (cnt == n_q) begin
              state <= MEM_DONE;
              if (owner_i) begin
                i_ready <= 1'b1;
                i_data  <= asm_next;
              end else begin
                d_ready <= 1'b1;
                d_rdata <= asm_next;
              end
            end
          end
        end

        MEM_DWRITE: begin
          if (cnt_inc < n_q) begin
            cnt      <= cnt_inc;
            mem_a    <= base + 32'(cnt_inc);
            mem_dout <= wdata_q[7:0];
            wdata_q  <= wdata_q >> 8;
          end else begin
            mem_wr  <= 1'b0;
            state   <= MEM_DONE;
            d_ready <= 1'b1;
          end
        end

        MEM_DONE: begin
          state <= MEM_IDLE;
        end

        default: begin
          state  <= MEM_IDLE;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        i_read = 1'b0, i_discard = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_busy, i_ready;
  logic [31:0] i_data;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_len = '0;
  logic        d_busy, d_ready;
  logic [31:0] d_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [2:0]  fsm_state;

  mem_ctrl dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_discard(i_discard),
    .i_busy(i_busy), .i_ready(i_ready), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_busy(d_busy), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .fsm_state(fsm_state)
  );

  // Synchronous RAM: read data appears the cycle after the address.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clock) begin
    if (ram.exists(mem_a)) mem_din <= ram[mem_a];
    else                   mem_din <= 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // The write strobe must only ever accompany the store state.
  always @(negedge clock) begin
    if (mem_wr) check("mem_wr_outside_dwrite", 32'(fsm_state), 32'(MEM_DWRITE));
  end

  // ---------------- driver tasks ----------------
  // Presents a data request in an idle cycle (cycle 0) and reports the cycle
  // in which d_ready was seen (-1 on timeout) plus d_rdata at that point.
  task automatic d_op(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
    @(negedge clock);
    d_addr = addr; d_len = len; d_wdata = wdata;
    d_write = wr; d_read = !wr;
    @(posedge clock);
    lat = -1; rdata = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) begin d_read = 1'b0; d_write = 1'b0; end
      if (d_ready) begin lat = c; rdata = d_rdata; break; end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];
  int          lat;
  logic [31:0] rd;
  int          n_iready, n_dready, t_iready, t_dready;

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h0008] = 8'hF0; ram[32'h0009] = 8'h77;

    vecs[0]  = '{1'b1, 2'd3, 32'h0000_0100, 32'h1122_3344, 32'h0,         5};
    vecs[1]  = '{1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'h1122_3344, 6};
    vecs[2]  = '{1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'h0000_1122, 4};
    vecs[3]  = '{1'b0, 2'd0, 32'h0000_0103, 32'h0,         32'h0000_0011, 3};
    vecs[4]  = '{1'b0, 2'd0, 32'h0000_0008, 32'h0,         32'h0000_00F0, 3};
    vecs[5]  = '{1'b1, 2'd0, 32'h0000_0101, 32'hAAAA_AA99, 32'h0,         2};
    vecs[6]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h1122_9944, 6};
    vecs[7]  = '{1'b1, 2'd1, 32'h0002_FFFF, 32'hDEAD_BEEF, 32'h0,         3};
    vecs[8]  = '{1'b0, 2'd1, 32'h0002_FFFF, 32'h0,         32'h0000_BEEF, 4};
    vecs[9]  = '{1'b1, 2'd3, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         5};
    vecs[10] = '{1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 6};
    vecs[11] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0,         32'h0000_00FE, 3};

    // ---- reset state ----
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("rst_busy",  {30'd0, i_busy, d_busy}, 32'h0);
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_wr_dout", {23'd0, mem_wr, mem_dout}, 32'h0);
    check("rst_i_data", i_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    // ---- instruction fetch timing at 0x1000 ----
    i_addr = 32'h1000; i_read = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c <= 4) check($sformatf("ifetch_mem_a_c%0d", c), mem_a, 32'h1000 + 32'(c - 1));
      check($sformatf("ifetch_busy_c%0d", c), {31'd0, i_busy}, {31'd0, c <= 6});
      check($sformatf("ifetch_ready_c%0d", c), {31'd0, i_ready}, {31'd0, c == 6});
      if (c == 6) begin
        check("ifetch_data", i_data, 32'h0000_0513);
        i_read = 1'b0;
      end
    end

    // ---- half-word store across 0x2FFFF, per-cycle RAM port ----
    @(negedge clock);
    d_addr = 32'h0002_FFFF; d_len = 2'd1; d_wdata = 32'hDEAD_BEEF; d_write = 1'b1;
    @(posedge clock);
    @(negedge clock); d_write = 1'b0;
    check("st_c1_wr", {31'd0, mem_wr}, 32'h1);
    check("st_c1_a", mem_a, 32'h0002_FFFF);
    check("st_c1_dout", {24'd0, mem_dout}, 32'h0000_00EF);
    @(negedge clock);
    check("st_c2_wr", {31'd0, mem_wr}, 32'h1);
    check("st_c2_a", mem_a, 32'h0003_0000);
    check("st_c2_dout", {24'd0, mem_dout}, 32'h0000_00BE);
    check("st_c2_noready", {31'd0, d_ready}, 32'h0);
    @(negedge clock);
    check("st_c3_wr", {31'd0, mem_wr}, 32'h0);
    check("st_c3_ready", {31'd0, d_ready}, 32'h1);

    // ---- data wins over simultaneous instruction request ----
    @(negedge clock);
    d_addr = 32'h8; d_len = 2'd0; d_read = 1'b1;
    i_addr = 32'h1000; i_read = 1'b1;
    n_iready = 0; n_dready = 0; t_iready = -1; t_dready = -1;
    @(posedge clock);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (c == 1) d_read = 1'b0;
      if (d_ready) begin n_dready++; t_dready = c; exp_q.push_back(32'h0000_00F0); check("prio_d_rdata", d_rdata, exp_q.pop_front()); end
      if (i_ready) begin n_iready++; t_iready = c; i_read = 1'b0; check("prio_i_data", i_data, 32'h0000_0513); end
    end
    check("prio_d_cycle", 32'(t_dready), 32'd3);
    check("prio_i_cycle", 32'(t_iready), 32'd10);
    check("prio_i_count", 32'(n_iready), 32'd1);
    check("prio_d_count", 32'(n_dready), 32'd1);

    // ---- table of data accesses ----
    foreach (vecs[i]) begin
      d_op(vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata, lat, rd);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].wr) begin
        exp_q.push_back(vecs[i].exp_rdata);
        check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      end
    end

    // ---- i_discard mid-fetch, then a new fetch right away ----
    @(negedge clock);
    i_addr = 32'h2000; i_read = 1'b1;
    n_iready = 0; t_iready = -1;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 3) i_discard = 1'b1;
      if (c == 4) begin
        check("disc_busy_c4", {31'd0, i_busy}, 32'h0);
        check("disc_i_data_held", i_data, 32'h0000_0513);
        i_discard = 1'b0;
        i_addr = 32'h100;
      end
      if (c == 5) check("disc_new_accept", {31'd0, i_busy}, 32'h1);
      if (i_ready) begin
        n_iready++; t_iready = c; i_read = 1'b0;
        check("disc_new_data", i_data, 32'h1122_9944);
      end
    end
    check("disc_ready_count", 32'(n_iready), 32'd1);
    check("disc_ready_cycle", 32'(t_iready), 32'd10);

    // ---- reset in the middle of a word store ----
    @(negedge clock);
    d_addr = 32'h300; d_len = 2'd3; d_wdata = 32'h5566_7788; d_write = 1'b1;
    @(posedge clock);
    @(negedge clock); d_write = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("rstmid_wr", {31'd0, mem_wr}, 32'h0);
    check("rstmid_busy", {31'd0, d_busy}, 32'h0);
    check("rstmid_outs", {d_rdata | i_data | mem_a}, 32'h0);
    reset = 1'b0;
    n_dready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (d_ready) n_dready++;
    end
    check("rstmid_no_ready", 32'(n_dready), 32'd0);
    check("rstmid_idle_busy", {31'd0, d_busy}, 32'h0);

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
